// File: rtl/core_pkg.sv
// core_pkg: shared func3 encodings and responder state type
// Ports: none (package)
package core_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: RV32I byte/half/word lane steering for loads and stores
// Ports: write (1=store), func3 (access size/sign), addr_lo (addr[1:0]), raw (stored word),
//        wdata (right-aligned store data); be (byte enables, zero for loads and errors),
//        wword (store data replicated across lanes), ldata (extended load, zero on error),
//        err (misaligned or illegal func3)
module mem_lane_align
    import core_pkg::*;
(
    input  logic        write,
    input  logic [2:0]  func3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] raw,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wword,
    output logic [31:0] ldata,
    output logic        err
);
    logic [7:0]  b;
    logic [15:0] h;
    logic        legal;
    logic        misalign;

    assign b = raw[{addr_lo, 3'b000} +: 8];
    assign h = raw[{addr_lo[1], 4'b0000} +: 16];

    // Unsigned variants only exist for loads
    assign legal = (func3 == F3_B) || (func3 == F3_H) || (func3 == F3_W) ||
                   (!write && ((func3 == F3_BU) || (func3 == F3_HU)));
    // func3[1:0] distinguishes half (01) from word (10) for both signed and unsigned forms
    assign misalign = ((func3[1:0] == 2'b01) && addr_lo[0]) ||
                      ((func3[1:0] == 2'b10) && (addr_lo != 2'b00));
    assign err = !legal || misalign;

    assign be = (!write || err)   ? 4'b0000 :
                (func3 == F3_B)   ? 4'b0001 << addr_lo :
                (func3 == F3_H)   ? (addr_lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;

    // Replicating the data into every lane lets the byte enables pick the target lane
    assign wword = (func3 == F3_B) ? {4{wdata[7:0]}} :
                   (func3 == F3_H) ? {2{wdata[15:0]}} : wdata;

    assign ldata = err               ? 32'd0 :
                   (func3 == F3_B)   ? {{24{b[7]}}, b} :
                   (func3 == F3_BU)  ? {24'd0, b} :
                   (func3 == F3_H)   ? {{16{h[15]}}, h} :
                   (func3 == F3_HU)  ? {16'd0, h} : raw;
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: load/store data memory with valid/ready request and response channels
// and a configurable number of wait states between acceptance and response
// Ports: clk, rst (async active-high); req_valid/req_ready, req_write, req_addr, req_wdata,
//        req_func3 (request channel); rsp_valid/rsp_ready, rsp_rdata, rsp_error (response channel)
module data_mem_responder
    import core_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_func3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t      state, next;
    logic [3:0]  cnt, cnt_n;
    logic        l_write;
    logic [31:0] l_addr, l_wdata;
    logic [2:0]  l_func3;
    logic        cur_write;
    logic [31:0] cur_addr, cur_wdata;
    logic [2:0]  cur_func3;
    logic [AW-1:0] idx;
    logic        oor, lane_err, err, commit;
    logic [3:0]  be;
    logic [31:0] wword, ldata, raw;
    logic [31:0] mem [DEPTH_WORDS];

    // With zero wait states the commit edge is the acceptance edge, so use live inputs
    assign cur_write = (state == IDLE) ? req_write : l_write;
    assign cur_addr  = (state == IDLE) ? req_addr  : l_addr;
    assign cur_wdata = (state == IDLE) ? req_wdata : l_wdata;
    assign cur_func3 = (state == IDLE) ? req_func3 : l_func3;

    assign idx    = cur_addr[AW+1:2];
    assign oor    = {2'b00, cur_addr[31:2]} >= 32'(DEPTH_WORDS);
    assign raw    = mem[idx];
    assign err    = lane_err || oor;
    assign commit = (next == RESP) && (state != RESP);

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

    mem_lane_align u_align (
        .write   (cur_write),
        .func3   (cur_func3),
        .addr_lo (cur_addr[1:0]),
        .raw     (raw),
        .wdata   (cur_wdata),
        .be      (be),
        .wword   (wword),
        .ldata   (ldata),
        .err     (lane_err)
    );

    always_comb begin
        next  = state;
        cnt_n = cnt;
        case (state)
            IDLE: if (req_valid) begin
                next  = (WAIT_CYCLES == 0) ? RESP : WAIT;
                cnt_n = CNT_INIT;
            end
            WAIT: begin
                cnt_n = cnt - 4'd1;
                if (cnt == 4'd0) next = RESP;
            end
            RESP: if (rsp_ready) next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            l_write   <= 1'b0;
            l_addr    <= 32'd0;
            l_wdata   <= 32'd0;
            l_func3   <= 3'd0;
            rsp_rdata <= 32'd0;
            rsp_error <= 1'b0;
        end else begin
            state <= next;
            cnt   <= cnt_n;
            if (state == IDLE && req_valid) begin
                l_write <= req_write;
                l_addr  <= req_addr;
                l_wdata <= req_wdata;
                l_func3 <= req_func3;
            end
            if (commit) begin
                rsp_rdata <= (err || cur_write) ? 32'd0 : ldata;
                rsp_error <= err;
            end
        end
    end

    // Storage is never reset; the rst term keeps a reset-held edge from committing
    always_ff @(posedge clk) begin
        if (commit && !rst && !oor)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
    end
endmodule
